// File: rtl/router_pkg.sv
// Shared widths, encap constants and FSM state type for the router TX path.
// ENCAP_MAGIC is only used when ENCAP_HEADER_EN is defined.
package router_pkg;

   localparam int DATA_WIDTH        = 1024;
   localparam int ADDR_WIDTH        = 10;
   localparam int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
   localparam int AURORA_DATA_WIDTH = 64;

   localparam int BEATS_PER_PKT =
      (DATA_DFX_WIDTH + AURORA_DATA_WIDTH - 1) / AURORA_DATA_WIDTH;

   localparam logic [15:0] ENCAP_MAGIC = 16'hDFC0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage

// File: rtl/encap_packet.sv
// Serialises one DFX word into LSB-first Aurora beats over valid/ready/last.
// Define ENCAP_HEADER_EN to prepend a {magic, beats, seq} header beat.
import router_pkg::*;

module encap_packet #(
   parameter int DATA_WIDTH        = router_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH        = router_pkg::ADDR_WIDTH,
   parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
   parameter int AURORA_DATA_WIDTH = router_pkg::AURORA_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
   input  logic                         valid_dfx_send,
   output logic                         ready_dfx_send,
   output logic [AURORA_DATA_WIDTH-1:0] tx_tdata,
   output logic                         tx_tvalid,
   input  logic                         tx_tready,
   output logic                         tx_tlast,
   output logic                         done_encap_pkt,
   output logic                         busy
);

   localparam int AW    = AURORA_DATA_WIDTH;
   localparam int BEATS = (DATA_DFX_WIDTH + AW - 1) / AW;
   localparam int PADW  = BEATS * AW;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

`ifdef ENCAP_HEADER_EN
   localparam state_t FIRST = HDR;
`else
   localparam state_t FIRST = SEND;
`endif

   state_t          state;
   state_t          state_nx;
   logic [PADW-1:0] sreg;
   logic [CW-1:0]   beat_cnt;
   logic            done_q;
   logic            in_send;
   logic            last_hs;
   logic            accept;

   assign in_send = (state == SEND);
   assign last_hs = in_send && (beat_cnt == LAST) && tx_tready;
   assign accept  = valid_dfx_send && ready_dfx_send;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = FIRST;
         HDR:  if (tx_tready) state_nx = SEND;
         SEND: if (last_hs) state_nx = accept ? FIRST : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Beat 0 sits in the low lane; each handshake shifts the next one down.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg     <= '0;
         beat_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= last_hs;
         if (accept) begin
            sreg     <= PADW'(data_dfx_send);
            beat_cnt <= '0;
         end else if (in_send && tx_tready) begin
            sreg     <= sreg >> AW;
            beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
         end
      end
   end

`ifdef ENCAP_HEADER_EN
   logic [31:0] pkt_seq;

   always_ff @(posedge clk) begin
      if (rst)          pkt_seq <= '0;
      else if (last_hs) pkt_seq <= pkt_seq + 32'd1;
   end
`endif

   always_comb begin
      ready_dfx_send = !rst && ((state == IDLE) || last_hs);
      tx_tvalid      = !rst && ((state == SEND) || (state == HDR));
      tx_tlast       = !rst && in_send && (beat_cnt == LAST);
      busy           = !rst && in_send;
      done_encap_pkt = !rst && done_q;
      tx_tdata       = rst ? '0 : sreg[AW-1:0];
`ifdef ENCAP_HEADER_EN
      if (!rst && state == HDR)
         tx_tdata = AW'({ENCAP_MAGIC, 16'(BEATS), pkt_seq});
`endif
   end

endmodule
